// File: rtl/bf_bus_ctrl.sv
// Bus slave for the BF interpreter core: routes fetch/data strobes to a
// synchronous SRAM and I/O strobes to RX/TX byte FIFOs, returning a valid pulse.

module bf_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clock_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

module bf_bus_ctrl #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wr_val_i,
   input  logic                  read_prog_i,
   input  logic                  read_data_i,
   input  logic                  write_data_i,
   input  logic                  read_io_i,
   input  logic                  write_io_i,
   output logic [DATA_WIDTH-1:0] rd_val_o,
   output logic                  valid_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_space_o,
   output logic                  mem_re_o,
   output logic                  mem_we_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  bus_error_o,
   output logic [2:0]            dbg_state_o
);
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_MEM_RD     = 3'd1,
      S_IO_RD_WAIT = 3'd2,
      S_IO_WR_WAIT = 3'd3,
      S_RESP       = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] rd_val_q, rd_val_d;
   logic                  bus_error_q, bus_error_d;
   logic [4:0]            strobes;
   logic                  one_stb, multi_stb;
   logic                  rx_pop, rx_full, rx_empty, tx_push, tx_full, tx_empty;
   logic [DATA_WIDTH-1:0] rx_rdata;

   assign strobes   = {read_prog_i, read_data_i, write_data_i, read_io_i, write_io_i};
   assign one_stb   = ($countones(strobes) == 1);
   assign multi_stb = ($countones(strobes) > 1);

   // The core holds addr/wr_val stable until valid, so these pass straight through.
   assign mem_addr_o  = addr_i;
   assign mem_space_o = read_data_i | write_data_i;
   assign mem_wdata_o = wr_val_i;
   assign rd_val_o    = rd_val_q;
   assign bus_error_o = bus_error_q;
   assign in_ready_o  = ~rx_full;
   assign out_valid_o = ~tx_empty;
   assign dbg_state_o = state_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         rd_val_q    <= '0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_val_q    <= rd_val_d;
         bus_error_q <= bus_error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (one_stb) begin
               if (read_prog_i | read_data_i) state_d = S_MEM_RD;
               else if (write_data_i)         state_d = S_RESP;
               else if (read_io_i)            state_d = rx_empty ? S_IO_RD_WAIT : S_RESP;
               else                           state_d = tx_full ? S_IO_WR_WAIT : S_RESP;
            end
         end
         S_MEM_RD:     state_d = S_RESP;
         S_IO_RD_WAIT: if (!rx_empty) state_d = S_RESP;
         S_IO_WR_WAIT: if (!tx_full) state_d = S_RESP;
         S_RESP:       state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_re_o    = 1'b0;
      mem_we_o    = 1'b0;
      rx_pop      = 1'b0;
      tx_push     = 1'b0;
      valid_o     = 1'b0;
      rd_val_d    = rd_val_q;
      bus_error_d = bus_error_q;
      unique case (state_q)
         S_IDLE: begin
            bus_error_d = bus_error_q | multi_stb;
            if (one_stb) begin
               mem_re_o = read_prog_i | read_data_i;
               mem_we_o = write_data_i;
               rx_pop   = read_io_i & ~rx_empty;
               tx_push  = write_io_i & ~tx_full;
            end
         end
         S_MEM_RD:     rd_val_d = mem_rdata_i;
         S_IO_RD_WAIT: rx_pop = ~rx_empty;
         S_IO_WR_WAIT: tx_push = ~tx_full;
         S_RESP:       valid_o = 1'b1;
         default:      ;
      endcase
      if (rx_pop) rd_val_d = rx_rdata;
   end

   bf_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .push_i  (in_valid_i),
      .wdata_i (in_data_i),
      .pop_i   (rx_pop),
      .rdata_o (rx_rdata),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );

   bf_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .push_i  (tx_push),
      .wdata_i (wr_val_i),
      .pop_i   (out_ready_i),
      .rdata_o (out_data_o),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );
endmodule

// File: tb/tb_bf_bus_ctrl.sv
// Directed bench for bf_bus_ctrl: SRAM model, core request driver and
// stream drivers, with hand-computed expectations.

module tb_bf_bus_ctrl;
   localparam logic [4:0] S_RP  = 5'b10000;
   localparam logic [4:0] S_RD  = 5'b01000;
   localparam logic [4:0] S_WD  = 5'b00100;
   localparam logic [4:0] S_RIO = 5'b00010;
   localparam logic [4:0] S_WIO = 5'b00001;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [14:0] addr = '0;
   logic [7:0]  wr_val = '0;
   logic        read_prog = 1'b0, read_data = 1'b0, write_data = 1'b0;
   logic        read_io = 1'b0, write_io = 1'b0;
   logic [7:0]  rd_val;
   logic        valid;
   logic [14:0] mem_addr;
   logic        mem_space, mem_re, mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        bus_error;
   logic [2:0]  dbg_state;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];
   logic [7:0] sram [0:1][0:32767];

   bf_bus_ctrl #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
      .clock_i(clock), .reset_i(reset), .addr_i(addr), .wr_val_i(wr_val),
      .read_prog_i(read_prog), .read_data_i(read_data), .write_data_i(write_data),
      .read_io_i(read_io), .write_io_i(write_io), .rd_val_o(rd_val), .valid_o(valid),
      .mem_addr_o(mem_addr), .mem_space_o(mem_space), .mem_re_o(mem_re),
      .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .bus_error_o(bus_error), .dbg_state_o(dbg_state)
   );

   // Clock and SRAM model (1-cycle read latency, preloaded during reset).
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (reset) begin
         mem_rdata <= 8'h00;
         sram[1][16] <= 8'h5A;
         sram[0][32767] <= 8'h3C;
      end else begin
         if (mem_re) mem_rdata <= sram[mem_space][mem_addr];
         if (mem_we) sram[mem_space][mem_addr] <= mem_wdata;
      end
   end

   // Core driver: issue one request at a negedge, hold it until valid.
   task automatic core_req(input logic [4:0] stb, input logic [14:0] a, input logic [7:0] w,
                           input int max_cyc, output int lat, output int n_re, output int n_we,
                           output logic space0, output logic [14:0] addr0);
      @(negedge clock);
      addr = a; wr_val = w;
      {read_prog, read_data, write_data, read_io, write_io} = stb;
      #1;
      space0 = mem_space; addr0 = mem_addr;
      lat = -1; n_re = 0; n_we = 0;
      for (int k = 0; k <= max_cyc; k++) begin
         if (k > 0) begin @(negedge clock); #1; end
         n_re += int'(mem_re);
         n_we += int'(mem_we);
         if (valid) begin lat = k; break; end
      end
      {read_prog, read_data, write_data, read_io, write_io} = 5'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%h exp=0", valid); end
      checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b%b exp=00", mem_re, mem_we); end
      checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL reset_bus_error got=%h exp=0", bus_error); end
      checks++; if (rd_val !== 8'h00) begin failures++; $display("FAIL reset_rd_val got=%h exp=00", rd_val); end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_fifos got=%b%b exp=10", in_ready, out_valid); end
      checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      reset = 1'b0;
   endtask

   task automatic test_mem_read();
      int lat, n_re, n_we; logic sp; logic [14:0] a0;
      core_req(S_RD, 15'h0010, 8'h00, 6, lat, n_re, n_we, sp, a0);
      checks++; if (lat !== 2) begin failures++; $display("FAIL rd_latency got=%0d exp=2", lat); end
      checks++; if (rd_val !== 8'h5A) begin failures++; $display("FAIL rd_val got=%h exp=5a", rd_val); end
      checks++; if (sp !== 1'b1 || a0 !== 15'h0010) begin failures++; $display("FAIL rd_space_addr got=%b/%h exp=1/0010", sp, a0); end
      checks++; if (n_re !== 1 || n_we !== 0) begin failures++; $display("FAIL rd_pulses got=re%0d we%0d exp=re1 we0", n_re, n_we); end
      @(negedge clock); #1;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rd_valid_single got=%h exp=0", valid); end
   endtask

   task automatic test_write_then_prog();
      int lat, n_re, n_we; logic sp; logic [14:0] a0;
      core_req(S_WD, 15'h7FFF, 8'hA5, 6, lat, n_re, n_we, sp, a0);
      checks++; if (lat !== 1) begin failures++; $display("FAIL wr_latency got=%0d exp=1", lat); end
      checks++; if (n_we !== 1 || n_re !== 0 || sp !== 1'b1) begin failures++; $display("FAIL wr_pulses got=we%0d re%0d sp%b exp=we1 re0 sp1", n_we, n_re, sp); end
      checks++; if (rd_val !== 8'h5A) begin failures++; $display("FAIL wr_rd_val_held got=%h exp=5a", rd_val); end
      @(negedge clock);
      checks++; if (sram[1][32767] !== 8'hA5) begin failures++; $display("FAIL wr_sram_data got=%h exp=a5", sram[1][32767]); end
      core_req(S_RP, 15'h7FFF, 8'h00, 6, lat, n_re, n_we, sp, a0);
      checks++; if (lat !== 2) begin failures++; $display("FAIL prog_latency got=%0d exp=2", lat); end
      checks++; if (sp !== 1'b0 || n_re !== 1) begin failures++; $display("FAIL prog_space got=sp%b re%0d exp=sp0 re1", sp, n_re); end
      checks++; if (rd_val !== 8'h3C) begin failures++; $display("FAIL prog_rd_val got=%h exp=3c", rd_val); end
   endtask

   task automatic test_io_read_wait();
      @(negedge clock);
      read_io = 1'b1; #1;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin @(negedge clock); #1; end
         checks++; if (valid !== 1'b0) begin failures++; $display("FAIL iord_wait_valid k=%0d got=%h exp=0", k, valid); end
      end
      checks++; if (dbg_state !== 3'd2) begin failures++; $display("FAIL iord_wait_state got=%0d exp=2", dbg_state); end
      @(negedge clock);
      in_data = 8'h41; in_valid = 1'b1; #1;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL iord_push_cycle got=%h exp=0", valid); end
      @(negedge clock);
      in_valid = 1'b0; #1;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL iord_push_p1 got=%h exp=0", valid); end
      @(negedge clock); #1;
      checks++; if (valid !== 1'b1 || rd_val !== 8'h41) begin failures++; $display("FAIL iord_push_p2 got=v%b %h exp=v1 41", valid, rd_val); end
      read_io = 1'b0;
   endtask

   task automatic test_tx_backpressure();
      int lat, n_re, n_we, lat5; logic sp, saw; logic [14:0] a0;
      logic [7:0] got[$];
      logic [7:0] e;
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         core_req(S_WIO, 15'h0, 8'(i), 4, lat, n_re, n_we, sp, a0);
         exp_q.push_back(8'(i));
         checks++; if (lat !== 1) begin failures++; $display("FAIL tx_push_lat i=%0d got=%0d exp=1", i, lat); end
      end
      @(negedge clock);
      write_io = 1'b1; wr_val = 8'h05; #1;
      exp_q.push_back(8'h05);
      saw = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin @(negedge clock); #1; end
         if (valid) saw = 1'b1;
      end
      checks++; if (saw !== 1'b0 || dbg_state !== 3'd3) begin failures++; $display("FAIL tx_stall got=v%b st%0d exp=v0 st3", saw, dbg_state); end
      lat5 = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (k == 0) out_ready = 1'b1;
         #1;
         if (out_valid) got.push_back(out_data);
         if (valid && !saw) begin saw = 1'b1; lat5 = k; write_io = 1'b0; end
      end
      write_io = 1'b0; out_ready = 1'b0;
      checks++; if (lat5 !== 2) begin failures++; $display("FAIL tx_stall_release got=%0d exp=2", lat5); end
      checks++; if (got.size() !== 5) begin failures++; $display("FAIL tx_count got=%0d exp=5", got.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got.size() > 0) begin
            checks++; if (got[0] !== e) begin failures++; $display("FAIL tx_order got=%h exp=%h", got[0], e); end
            void'(got.pop_front());
         end
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL tx_drained got=%h exp=0", out_valid); end
   endtask

   task automatic test_rx_full_wrap();
      int lat, n_re, n_we; logic sp; logic [14:0] a0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         in_valid = 1'b1; in_data = 8'h10 + 8'(i);
      end
      @(negedge clock);
      in_data = 8'h14; #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rx_full got=%h exp=0", in_ready); end
      core_req(S_RIO, 15'h0, 8'h00, 4, lat, n_re, n_we, sp, a0);
      checks++; if (lat !== 1 || rd_val !== 8'h10) begin failures++; $display("FAIL rx_pop_full got=lat%0d %h exp=lat1 10", lat, rd_val); end
      @(negedge clock);
      in_valid = 1'b0; #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rx_refill got=%h exp=0", in_ready); end
      for (int i = 1; i <= 4; i++) begin
         core_req(S_RIO, 15'h0, 8'h00, 4, lat, n_re, n_we, sp, a0);
         checks++; if (lat !== 1 || rd_val !== 8'h10 + 8'(i)) begin failures++; $display("FAIL rx_wrap i=%0d got=lat%0d %h exp=lat1 %h", i, lat, rd_val, 8'h10 + 8'(i)); end
      end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rx_empty_ready got=%h exp=1", in_ready); end
   endtask

   task automatic test_error_and_reset();
      int lat, n_re, n_we; logic sp; logic [14:0] a0;
      @(negedge clock); in_valid = 1'b1; in_data = 8'h77;
      @(negedge clock); in_valid = 1'b0;
      core_req(S_WIO, 15'h0, 8'h88, 4, lat, n_re, n_we, sp, a0);
      @(negedge clock);
      read_data = 1'b1; write_io = 1'b1; addr = 15'h0010; #1;
      checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL err_no_access got=%b%b exp=00", mem_re, mem_we); end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock); #1;
         checks++; if (valid !== 1'b0 || bus_error !== 1'b1) begin failures++; $display("FAIL err_flag k=%0d got=v%b e%b exp=v0 e1", k, valid, bus_error); end
      end
      read_data = 1'b0; write_io = 1'b0;
      @(negedge clock); #1;
      checks++; if (bus_error !== 1'b1 || dbg_state !== 3'd0) begin failures++; $display("FAIL err_sticky got=e%b st%0d exp=e1 st0", bus_error, dbg_state); end
      @(negedge clock);
      read_data = 1'b1; #1;
      checks++; if (mem_re !== 1'b1) begin failures++; $display("FAIL err_read_blocked got=%h exp=1", mem_re); end
      @(negedge clock); #1;
      checks++; if (dbg_state !== 3'd1) begin failures++; $display("FAIL rst_mem_rd_state got=%0d exp=1", dbg_state); end
      reset = 1'b1; read_data = 1'b0;
      @(negedge clock); #1;
      checks++; if (valid !== 1'b0 || bus_error !== 1'b0 || dbg_state !== 3'd0) begin failures++; $display("FAIL rst_mid got=v%b e%b st%0d exp=v0 e0 st0", valid, bus_error, dbg_state); end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || rd_val !== 8'h00) begin failures++; $display("FAIL rst_mid_fifos got=r%b o%b %h exp=r1 o0 00", in_ready, out_valid, rd_val); end
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock); #1;
         checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_no_valid k=%0d got=%h exp=0", k, valid); end
      end
   endtask

   initial begin
      test_reset();
      test_mem_read();
      test_write_then_prog();
      test_io_read_wait();
      test_tx_backpressure();
      test_rx_full_wrap();
      test_error_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
